i2c_txn_sequencer: RTL and testbench
====================================

// Module: i2c_txn_sequencer
// PURPOSE
//  Upstream command/data sequencer for i2c_master. It takes one transaction request (7-bit address,
//  direction, byte count). It emits the matching s_axis_cmd_* beats and write-data beats to the master,
//  and passes received read bytes to a downstream AXI-stream. It reports per-transaction done/NACK status.
//  It sits between stream_gen/muxDataGen-style stimulus sources and each i2c_master instance.
// PARAMETERS
//  LEN_W      8   width of req_len; max transaction = 2**LEN_W-1 bytes
//  WAIT_MAX   4095 cycles allowed in WAIT_IDLE for master busy to fall; exceeding sets err_timeout
// PORTS
//  clk            in   1      single clock; all logic on posedge
//  rst            in   1      asynchronous, active-high reset
//  req_valid      in   1      transaction request valid
//  req_ready      out  1      high only in IDLE
//  req_addr       in   7      target slave address
//  req_read       in   1      1=read, 0=write
//  req_len        in   LEN_W  byte count; 0 is rejected
//  wr_tdata/tvalid/tlast in 8/1/1, wr_tready out 1   write payload from stream source
//  rd_tdata/tvalid/tlast out 8/1/1, rd_tready in 1   read payload to consumer
//  cmd_address/start/read/write/write_multiple/stop/valid out 7/1/1/1/1/1/1; cmd_ready in 1  -> master s_axis_cmd_*
//  mdat_tdata/tvalid/tlast out 8/1/1; mdat_tready in 1     -> master s_axis_data_*
//  mrd_tdata/tvalid/tlast in 8/1/1;  mrd_tready out 1      <- master m_axis_data_*
//  m_busy, m_missed_ack  in 1 each   master busy / missed_ack
//  done           out  1      one-cycle pulse at transaction end (also on rejected request)
//  err_nack, err_len, err_timeout  out 1 each   sticky status, cleared on next accepted request
//  bytes_done     out  LEN_W  bytes transferred in current/last transaction
// BEHAVIOUR
//  Reset: every output 0, FSM=IDLE. req_ready rises on the first clk after rst deasserts.
//  Request accept: req_valid&req_ready. Latch addr/read/len, clear err_* and bytes_done, byte counter=len.
//  req_len==0: set err_len, pulse done next cycle, stay IDLE, no bus activity.
//  FSM states:
//   IDLE -> WCMD (write) | RCMD (read).
//   WCMD: one beat {start=1,write_multiple=1,stop=1,address}; hold cmd_valid until cmd_ready; -> WDATA.
//   WDATA: mdat_* = wr_* pass-through (combinational), wr_tready=mdat_tready. Each handshake decrements
//    the counter and increments bytes_done. mdat_tlast is forced 1 on the counter==1 beat regardless of wr_tlast.
//    wr_tlast early or missing vs counter sets err_len; the byte count still governs. Counter 0 -> WAIT_IDLE.
//   RCMD: issue read command beats {read=1,address}: start=1 on the first beat only, stop=1 on the
//    counter==1 beat. After each cmd handshake -> RDATA.
//   RDATA: rd_* = mrd_* pass-through, mrd_tready=rd_tready. rd_tlast forced 1 on the final byte.
//    Handshake decrements the counter; nonzero -> RCMD, zero -> WAIT_IDLE.
//   WAIT_IDLE: wait until m_busy==0; pulse done; -> IDLE. WAIT_MAX expiry sets err_timeout, pulses done, -> IDLE.
//  cmd_valid, once asserted, never drops or changes fields until cmd_ready (AXI rule); same for mdat/rd valid.
//  m_missed_ack pulse in any non-IDLE state sets err_nack.
//   The transaction still runs to completion: write bytes are drained, read bytes are delivered.
//  Simultaneous: a done pulse and a new req_valid in the same cycle do not accept the request.
//   Acceptance occurs only when req_ready=1, i.e. the cycle after done.
//  Counter width LEN_W, no wrap: decrement only on handshake with counter>0.
//  Async reset mid-transaction: all valids drop immediately and the FSM returns to IDLE.
//   The master is reset alongside by the system.
// STRUCTURE
//  Package i2c_seq_pkg: seq_state_t enum {IDLE,WCMD,WDATA,RCMD,RDATA,WAIT_IDLE} and i2c_cmd_t struct
//   (address,start,read,write,write_multiple,stop), shared with i2c_master stimulus benches.
//  Single FSM with a registered command beat. Data paths are combinational muxes gated by state.
//  One natural sub-module: i2c_seq_timeout (WAIT_MAX down-counter, load/expire).
// TESTING
//  1 write addr 0x22 len 3 data A5,5A,FF -> one cmd beat start/wm/stop; 3 mdat beats, tlast on FF; done; bytes_done=3
//  2 read addr 0x37 len 2, slave returns 11,22 -> cmd beats start=1/stop=0 then start=0/stop=1; rd 11,22, tlast on 22
//  3 req_len=0 -> err_len=1, done pulse 1 cycle later, cmd_valid never asserted
//  4 write to unmapped addr 0x10 len 1 -> m_missed_ack seen, err_nack=1, done still pulses, req_ready returns
//  5 write len 4 with wr_tlast on byte 2 -> err_len=1, mdat_tlast only on 4th beat, bytes_done=4
//  6 rst asserted in RDATA with rd_tready=0 -> rd_tvalid/cmd_valid 0 same cycle; after release req_ready=1, err_*=0

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C transaction sequencer and the benches that drive i2c_master.
// Holds the FSM state encoding, the command-beat payload and helpers that build command beats.
package i2c_seq_pkg;

   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WCMD      = 3'd1,
      S_WDATA     = 3'd2,
      S_RCMD      = 3'd3,
      S_RDATA     = 3'd4,
      S_WAIT_IDLE = 3'd5
   } seq_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] address;
      logic              start;
      logic              read;
      logic              write;
      logic              write_multiple;
      logic              stop;
   } i2c_cmd_t;

   // Whole write transaction goes out as a single write_multiple beat framed by start/stop.
   function automatic i2c_cmd_t write_cmd(input logic [ADDR_W-1:0] addr);
      i2c_cmd_t c;
      c                = '0;
      c.address        = addr;
      c.start          = 1'b1;
      c.write_multiple = 1'b1;
      c.stop           = 1'b1;
      return c;
   endfunction

   // Reads are issued one byte per beat; start only on the first, stop only on the last.
   function automatic i2c_cmd_t read_cmd(input logic [ADDR_W-1:0] addr,
                                         input logic first,
                                         input logic last);
      i2c_cmd_t c;
      c         = '0;
      c.address = addr;
      c.read    = 1'b1;
      c.start   = first;
      c.stop    = last;
      return c;
   endfunction

endpackage

// File: rtl/i2c_seq_timeout.sv
// Watchdog for the WAIT_IDLE phase: loads WAIT_MAX, counts down while enabled,
// and flags expiry once the count has run out with the master still busy.
module i2c_seq_timeout #(
   parameter int unsigned WAIT_MAX = 4095
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expired_q, expired_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         expired_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         expired_q <= expired_d;
      end
   end

   always_comb begin
      cnt_d     = cnt_q;
      expired_d = expired_q;
      if (load_i) begin
         cnt_d     = CNT_W'(WAIT_MAX);
         expired_d = 1'b0;
      end else if (en_i) begin
         if (cnt_q == '0) expired_d = 1'b1;
         else             cnt_d     = cnt_q - CNT_W'(1);
      end
   end

   assign expired_o = expired_q;

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Upstream sequencer for i2c_master: turns one request into command/data beats,
// forwards read bytes downstream and reports done plus sticky NACK/length/timeout status.
module i2c_txn_sequencer
   import i2c_seq_pkg::*;
#(
   parameter int unsigned LEN_W    = 8,
   parameter int unsigned WAIT_MAX = 4095
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic              req_read_i,
   input  logic [LEN_W-1:0]  req_len_i,
   input  logic [DATA_W-1:0] wr_tdata_i,
   input  logic              wr_tvalid_i,
   input  logic              wr_tlast_i,
   output logic              wr_tready_o,
   output logic [DATA_W-1:0] rd_tdata_o,
   output logic              rd_tvalid_o,
   output logic              rd_tlast_o,
   input  logic              rd_tready_i,
   output logic [ADDR_W-1:0] cmd_address_o,
   output logic              cmd_start_o,
   output logic              cmd_read_o,
   output logic              cmd_write_o,
   output logic              cmd_write_multiple_o,
   output logic              cmd_stop_o,
   output logic              cmd_valid_o,
   input  logic              cmd_ready_i,
   output logic [DATA_W-1:0] mdat_tdata_o,
   output logic              mdat_tvalid_o,
   output logic              mdat_tlast_o,
   input  logic              mdat_tready_i,
   input  logic [DATA_W-1:0] mrd_tdata_i,
   input  logic              mrd_tvalid_i,
   input  logic              mrd_tlast_i,
   output logic              mrd_tready_o,
   input  logic              m_busy_i,
   input  logic              m_missed_ack_i,
   output logic              done_o,
   output logic              err_nack_o,
   output logic              err_len_o,
   output logic              err_timeout_o,
   output logic [LEN_W-1:0]  bytes_done_o
);

   seq_state_t       state_q, state_d;
   i2c_cmd_t         cmd_q, cmd_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] bytes_q, bytes_d;
   logic             req_ready_q, req_ready_d;
   logic             done_q, done_d;
   logic             err_nack_q, err_nack_d;
   logic             err_len_q, err_len_d;
   logic             err_to_q, err_to_d;

   logic accept, cmd_hs, wr_hs, rd_hs, last_beat;
   logic in_wdata, in_rdata;
   logic to_load, to_expired;

   i2c_seq_timeout #(
      .WAIT_MAX (WAIT_MAX)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .load_i    (to_load),
      .en_i      (state_q == S_WAIT_IDLE),
      .expired_o (to_expired)
   );

   // Data paths are combinational pass-throughs, gated off outside their phase.
   assign last_beat     = (cnt_q == LEN_W'(1));
   assign in_wdata      = (state_q == S_WDATA) && (cnt_q != '0);
   assign in_rdata      = (state_q == S_RDATA) && (cnt_q != '0);

   assign mdat_tdata_o  = in_wdata ? wr_tdata_i : '0;
   assign mdat_tvalid_o = in_wdata && wr_tvalid_i;
   assign mdat_tlast_o  = in_wdata && last_beat;
   assign wr_tready_o   = in_wdata && mdat_tready_i;

   assign rd_tdata_o    = in_rdata ? mrd_tdata_i : '0;
   assign rd_tvalid_o   = in_rdata && mrd_tvalid_i;
   assign rd_tlast_o    = in_rdata && (last_beat || mrd_tlast_i);
   assign mrd_tready_o  = in_rdata && rd_tready_i;

   assign accept = req_valid_i && req_ready_q;
   assign cmd_hs = cmd_valid_q && cmd_ready_i;
   assign wr_hs  = mdat_tvalid_o && mdat_tready_i;
   assign rd_hs  = rd_tvalid_o && rd_tready_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
         cnt_q       <= '0;
         bytes_q     <= '0;
         req_ready_q <= 1'b0;
         done_q      <= 1'b0;
         err_nack_q  <= 1'b0;
         err_len_q   <= 1'b0;
         err_to_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
         cnt_q       <= cnt_d;
         bytes_q     <= bytes_d;
         req_ready_q <= req_ready_d;
         done_q      <= done_d;
         err_nack_q  <= err_nack_d;
         err_len_q   <= err_len_d;
         err_to_q    <= err_to_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      cmd_valid_d = cmd_valid_q;
      cnt_d       = cnt_q;
      bytes_d     = bytes_q;
      done_d      = 1'b0;
      err_nack_d  = err_nack_q;
      err_len_d   = err_len_q;
      err_to_d    = err_to_q;
      to_load     = 1'b0;

      if ((state_q != S_IDLE) && m_missed_ack_i) err_nack_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               err_nack_d = 1'b0;
               err_len_d  = 1'b0;
               err_to_d   = 1'b0;
               bytes_d    = '0;
               cnt_d      = req_len_i;
               if (req_len_i == '0) begin
                  err_len_d = 1'b1;
                  done_d    = 1'b1;
               end else if (req_read_i) begin
                  cmd_d       = read_cmd(req_addr_i, 1'b1, req_len_i == LEN_W'(1));
                  cmd_valid_d = 1'b1;
                  state_d     = S_RCMD;
               end else begin
                  cmd_d       = write_cmd(req_addr_i);
                  cmd_valid_d = 1'b1;
                  state_d     = S_WCMD;
               end
            end
         end
         S_WCMD: begin
            if (cmd_hs) begin
               cmd_valid_d = 1'b0;
               state_d     = S_WDATA;
            end
         end
         S_WDATA: begin
            if (wr_hs) begin
               cnt_d   = cnt_q - LEN_W'(1);
               bytes_d = bytes_q + LEN_W'(1);
               // Source framing must agree with the requested length; the count still wins.
               if (wr_tlast_i != last_beat) err_len_d = 1'b1;
               if (last_beat) begin
                  state_d = S_WAIT_IDLE;
                  to_load = 1'b1;
               end
            end
         end
         S_RCMD: begin
            if (cmd_hs) begin
               cmd_valid_d = 1'b0;
               state_d     = S_RDATA;
            end
         end
         S_RDATA: begin
            if (rd_hs) begin
               cnt_d   = cnt_q - LEN_W'(1);
               bytes_d = bytes_q + LEN_W'(1);
               if (last_beat) begin
                  state_d = S_WAIT_IDLE;
                  to_load = 1'b1;
               end else begin
                  cmd_d       = read_cmd(cmd_q.address, 1'b0, cnt_q == LEN_W'(2));
                  cmd_valid_d = 1'b1;
                  state_d     = S_RCMD;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (!m_busy_i) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else if (to_expired) begin
               err_to_d = 1'b1;
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: begin
            state_d     = S_IDLE;
            cmd_valid_d = 1'b0;
         end
      endcase

      // A request arriving alongside done must wait one cycle.
      req_ready_d = (state_d == S_IDLE) && !done_d;
   end

   assign req_ready_o          = req_ready_q;
   assign cmd_address_o        = cmd_q.address;
   assign cmd_start_o          = cmd_q.start;
   assign cmd_read_o           = cmd_q.read;
   assign cmd_write_o          = cmd_q.write;
   assign cmd_write_multiple_o = cmd_q.write_multiple;
   assign cmd_stop_o           = cmd_q.stop;
   assign cmd_valid_o          = cmd_valid_q;
   assign done_o               = done_q;
   assign err_nack_o           = err_nack_q;
   assign err_len_o            = err_len_q;
   assign err_timeout_o        = err_to_q;
   assign bytes_done_o         = bytes_q;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer; the bench plays stream source, consumer and i2c_master.
module tb_i2c_txn_sequencer;

   localparam int unsigned LEN_W    = 8;
   localparam int unsigned WAIT_MAX = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0, req_read = 1'b0;
   logic [6:0]       req_addr = '0;
   logic [LEN_W-1:0] req_len = '0;
   logic [7:0]       wr_tdata = '0;
   logic             wr_tvalid = 1'b0, wr_tlast = 1'b0, rd_tready = 1'b0;
   logic             cmd_ready = 1'b0, mdat_tready = 1'b0;
   logic [7:0]       mrd_tdata = '0;
   logic             mrd_tvalid = 1'b0, mrd_tlast = 1'b0;
   logic             m_busy = 1'b0, m_missed_ack = 1'b0;

   logic             req_ready_o, wr_tready_o, rd_tvalid_o, rd_tlast_o;
   logic [7:0]       rd_tdata_o, mdat_tdata_o;
   logic [6:0]       cmd_address_o;
   logic             cmd_start_o, cmd_read_o, cmd_write_o, cmd_write_multiple_o, cmd_stop_o, cmd_valid_o;
   logic             mdat_tvalid_o, mdat_tlast_o, mrd_tready_o;
   logic             done_o, err_nack_o, err_len_o, err_timeout_o;
   logic [LEN_W-1:0] bytes_done_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   i2c_txn_sequencer #(.LEN_W(LEN_W), .WAIT_MAX(WAIT_MAX)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_addr_i(req_addr),
      .req_read_i(req_read), .req_len_i(req_len),
      .wr_tdata_i(wr_tdata), .wr_tvalid_i(wr_tvalid), .wr_tlast_i(wr_tlast), .wr_tready_o(wr_tready_o),
      .rd_tdata_o(rd_tdata_o), .rd_tvalid_o(rd_tvalid_o), .rd_tlast_o(rd_tlast_o), .rd_tready_i(rd_tready),
      .cmd_address_o(cmd_address_o), .cmd_start_o(cmd_start_o), .cmd_read_o(cmd_read_o),
      .cmd_write_o(cmd_write_o), .cmd_write_multiple_o(cmd_write_multiple_o), .cmd_stop_o(cmd_stop_o),
      .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready),
      .mdat_tdata_o(mdat_tdata_o), .mdat_tvalid_o(mdat_tvalid_o), .mdat_tlast_o(mdat_tlast_o),
      .mdat_tready_i(mdat_tready),
      .mrd_tdata_i(mrd_tdata), .mrd_tvalid_i(mrd_tvalid), .mrd_tlast_i(mrd_tlast), .mrd_tready_o(mrd_tready_o),
      .m_busy_i(m_busy), .m_missed_ack_i(m_missed_ack),
      .done_o(done_o), .err_nack_o(err_nack_o), .err_len_o(err_len_o), .err_timeout_o(err_timeout_o),
      .bytes_done_o(bytes_done_o)
   );

   // Present a request for one clock; returns at the falling edge after acceptance.
   task automatic do_req(input logic [6:0] a, input logic rd, input logic [LEN_W-1:0] n);
      req_addr = a; req_read = rd; req_len = n; req_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic cmd_handshake();
      cmd_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      cmd_ready = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (done_o === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (req_ready_o !== 1'b0 || cmd_valid_o !== 1'b0 || done_o !== 1'b0 || err_nack_o !== 1'b0 ||
          err_len_o !== 1'b0 || err_timeout_o !== 1'b0 || bytes_done_o !== 8'd0 || mdat_tvalid_o !== 1'b0 ||
          rd_tvalid_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: rdy=%b cv=%b done=%b errs=%b%b%b bytes=%0d want all 0",
                  req_ready_o, cmd_valid_o, done_o, err_nack_o, err_len_o, err_timeout_o, bytes_done_o);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready_o !== 1'b1) begin
         errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready_o);
      end
   endtask

   task automatic test_write();
      logic [7:0] dat [3];
      bit seen;
      dat = '{8'hA5, 8'h5A, 8'hFF};
      do_req(7'h22, 1'b0, 8'd3);
      checks++;
      if (cmd_valid_o !== 1'b1 || cmd_address_o !== 7'h22 || cmd_start_o !== 1'b1 || cmd_write_multiple_o !== 1'b1 ||
          cmd_stop_o !== 1'b1 || cmd_read_o !== 1'b0 || cmd_write_o !== 1'b0) begin
         errors++;
         $display("FAIL write_cmd_beat: v=%b a=%h s=%b wm=%b p=%b r=%b w=%b want v=1 a=22 s=1 wm=1 p=1 r=0 w=0",
                  cmd_valid_o, cmd_address_o, cmd_start_o, cmd_write_multiple_o, cmd_stop_o, cmd_read_o, cmd_write_o);
      end
      @(negedge clk);
      checks++;
      if (cmd_valid_o !== 1'b1 || cmd_address_o !== 7'h22) begin
         errors++; $display("FAIL write_cmd_hold: v=%b a=%h want v=1 a=22", cmd_valid_o, cmd_address_o);
      end
      cmd_handshake();
      m_busy = 1'b1;
      checks++;
      if (cmd_valid_o !== 1'b0) begin
         errors++; $display("FAIL write_cmd_drop: got %b want 0", cmd_valid_o);
      end
      for (int i = 0; i < 3; i++) begin
         wr_tdata = dat[i]; wr_tvalid = 1'b1; wr_tlast = (i == 2); mdat_tready = 1'b1;
         #1;
         checks++;
         if (mdat_tvalid_o !== 1'b1 || mdat_tdata_o !== dat[i] || mdat_tlast_o !== (i == 2) || wr_tready_o !== 1'b1) begin
            errors++;
            $display("FAIL write_beat%0d: v=%b d=%h l=%b rdy=%b want v=1 d=%h l=%b rdy=1",
                     i, mdat_tvalid_o, mdat_tdata_o, mdat_tlast_o, wr_tready_o, dat[i], (i == 2));
         end
         @(posedge clk); @(negedge clk);
      end
      wr_tvalid = 1'b0; wr_tlast = 1'b0; mdat_tready = 1'b0; m_busy = 1'b0;
      wait_done(20, seen);
      checks++;
      if (!seen) begin
         errors++; $display("FAIL write_done: got no done pulse want pulse");
      end
      checks++;
      if (bytes_done_o !== 8'd3 || err_len_o !== 1'b0 || err_nack_o !== 1'b0 || req_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL write_status: bytes=%0d len=%b nack=%b rdy=%b want bytes=3 len=0 nack=0 rdy=0",
                  bytes_done_o, err_len_o, err_nack_o, req_ready_o);
      end
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || req_ready_o !== 1'b1) begin
         errors++; $display("FAIL write_after_done: done=%b rdy=%b want done=0 rdy=1", done_o, req_ready_o);
      end
   endtask

   task automatic test_read();
      bit seen;
      do_req(7'h37, 1'b1, 8'd2);
      checks++;
      if (cmd_valid_o !== 1'b1 || cmd_address_o !== 7'h37 || cmd_read_o !== 1'b1 || cmd_start_o !== 1'b1 ||
          cmd_stop_o !== 1'b0 || cmd_write_multiple_o !== 1'b0) begin
         errors++;
         $display("FAIL read_cmd1: v=%b a=%h r=%b s=%b p=%b wm=%b want v=1 a=37 r=1 s=1 p=0 wm=0",
                  cmd_valid_o, cmd_address_o, cmd_read_o, cmd_start_o, cmd_stop_o, cmd_write_multiple_o);
      end
      cmd_handshake();
      m_busy = 1'b1;
      mrd_tdata = 8'h11; mrd_tvalid = 1'b1; mrd_tlast = 1'b0; rd_tready = 1'b1;
      #1;
      checks++;
      if (rd_tvalid_o !== 1'b1 || rd_tdata_o !== 8'h11 || rd_tlast_o !== 1'b0 || mrd_tready_o !== 1'b1) begin
         errors++;
         $display("FAIL read_byte0: v=%b d=%h l=%b rdy=%b want v=1 d=11 l=0 rdy=1",
                  rd_tvalid_o, rd_tdata_o, rd_tlast_o, mrd_tready_o);
      end
      @(posedge clk); @(negedge clk);
      mrd_tvalid = 1'b0;
      #1;
      checks++;
      if (cmd_valid_o !== 1'b1 || cmd_start_o !== 1'b0 || cmd_stop_o !== 1'b1 || cmd_read_o !== 1'b1 ||
          cmd_address_o !== 7'h37 || rd_tvalid_o !== 1'b0 || bytes_done_o !== 8'd1) begin
         errors++;
         $display("FAIL read_cmd2: v=%b s=%b p=%b r=%b a=%h rdv=%b bytes=%0d want v=1 s=0 p=1 r=1 a=37 rdv=0 bytes=1",
                  cmd_valid_o, cmd_start_o, cmd_stop_o, cmd_read_o, cmd_address_o, rd_tvalid_o, bytes_done_o);
      end
      cmd_handshake();
      mrd_tdata = 8'h22; mrd_tvalid = 1'b1; mrd_tlast = 1'b0;
      #1;
      checks++;
      if (rd_tvalid_o !== 1'b1 || rd_tdata_o !== 8'h22 || rd_tlast_o !== 1'b1) begin
         errors++;
         $display("FAIL read_byte1: v=%b d=%h l=%b want v=1 d=22 l=1", rd_tvalid_o, rd_tdata_o, rd_tlast_o);
      end
      @(posedge clk); @(negedge clk);
      mrd_tvalid = 1'b0; rd_tready = 1'b0; m_busy = 1'b0;
      wait_done(20, seen);
      checks++;
      if (!seen || bytes_done_o !== 8'd2 || err_len_o !== 1'b0 || err_nack_o !== 1'b0) begin
         errors++;
         $display("FAIL read_done: seen=%b bytes=%0d len=%b nack=%b want seen=1 bytes=2 len=0 nack=0",
                  seen, bytes_done_o, err_len_o, err_nack_o);
      end
      @(negedge clk);
   endtask

   task automatic test_len_zero();
      do_req(7'h05, 1'b0, 8'd0);
      checks++;
      if (done_o !== 1'b1 || err_len_o !== 1'b1 || cmd_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL len0_reject: done=%b len=%b cv=%b rdy=%b want done=1 len=1 cv=0 rdy=0",
                  done_o, err_len_o, cmd_valid_o, req_ready_o);
      end
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || req_ready_o !== 1'b1 || cmd_valid_o !== 1'b0 || err_len_o !== 1'b1) begin
         errors++;
         $display("FAIL len0_after: done=%b rdy=%b cv=%b len=%b want done=0 rdy=1 cv=0 len=1",
                  done_o, req_ready_o, cmd_valid_o, err_len_o);
      end
   endtask

   task automatic test_nack();
      bit seen;
      do_req(7'h10, 1'b0, 8'd1);
      checks++;
      if (err_len_o !== 1'b0 || cmd_valid_o !== 1'b1 || cmd_address_o !== 7'h10) begin
         errors++;
         $display("FAIL nack_accept: len=%b cv=%b a=%h want len=0 cv=1 a=10", err_len_o, cmd_valid_o, cmd_address_o);
      end
      cmd_handshake();
      m_busy = 1'b1; m_missed_ack = 1'b1;
      @(posedge clk); @(negedge clk);
      m_missed_ack = 1'b0;
      checks++;
      if (err_nack_o !== 1'b1) begin
         errors++; $display("FAIL nack_flag: got %b want 1", err_nack_o);
      end
      wr_tdata = 8'h3C; wr_tvalid = 1'b1; wr_tlast = 1'b1; mdat_tready = 1'b1;
      #1;
      checks++;
      if (mdat_tvalid_o !== 1'b1 || mdat_tdata_o !== 8'h3C || mdat_tlast_o !== 1'b1) begin
         errors++;
         $display("FAIL nack_drain: v=%b d=%h l=%b want v=1 d=3c l=1", mdat_tvalid_o, mdat_tdata_o, mdat_tlast_o);
      end
      @(posedge clk); @(negedge clk);
      wr_tvalid = 1'b0; wr_tlast = 1'b0; mdat_tready = 1'b0; m_busy = 1'b0;
      wait_done(20, seen);
      checks++;
      if (!seen || err_nack_o !== 1'b1 || bytes_done_o !== 8'd1) begin
         errors++;
         $display("FAIL nack_done: seen=%b nack=%b bytes=%0d want seen=1 nack=1 bytes=1", seen, err_nack_o, bytes_done_o);
      end
      @(negedge clk);
      checks++;
      if (req_ready_o !== 1'b1) begin
         errors++; $display("FAIL nack_ready: got %b want 1", req_ready_o);
      end
   endtask

   task automatic test_early_tlast();
      bit seen;
      do_req(7'h2A, 1'b0, 8'd4);
      checks++;
      if (err_nack_o !== 1'b0) begin
         errors++; $display("FAIL tlast_nack_clear: got %b want 0", err_nack_o);
      end
      cmd_handshake();
      m_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr_tdata = 8'(i + 1); wr_tvalid = 1'b1; wr_tlast = (i == 1); mdat_tready = 1'b1;
         #1;
         checks++;
         if (mdat_tlast_o !== (i == 3) || mdat_tdata_o !== 8'(i + 1)) begin
            errors++;
            $display("FAIL tlast_beat%0d: l=%b d=%h want l=%b d=%h", i, mdat_tlast_o, mdat_tdata_o, (i == 3), 8'(i + 1));
         end
         @(posedge clk); @(negedge clk);
      end
      wr_tvalid = 1'b0; wr_tlast = 1'b0; mdat_tready = 1'b0; m_busy = 1'b0;
      wait_done(20, seen);
      checks++;
      if (!seen || err_len_o !== 1'b1 || bytes_done_o !== 8'd4) begin
         errors++;
         $display("FAIL tlast_done: seen=%b len=%b bytes=%0d want seen=1 len=1 bytes=4", seen, err_len_o, bytes_done_o);
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      bit seen;
      bit early;
      do_req(7'h44, 1'b0, 8'd1);
      cmd_handshake();
      m_busy = 1'b1;
      wr_tdata = 8'h77; wr_tvalid = 1'b1; wr_tlast = 1'b1; mdat_tready = 1'b1;
      @(posedge clk); @(negedge clk);
      wr_tvalid = 1'b0; wr_tlast = 1'b0; mdat_tready = 1'b0;
      early = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (done_o !== 1'b0) early = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (early) begin
         errors++; $display("FAIL timeout_early_done: got done while busy want none within 5 cycles");
      end
      wait_done(60, seen);
      checks++;
      if (!seen || err_timeout_o !== 1'b1 || err_len_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_expire: seen=%b to=%b len=%b want seen=1 to=1 len=0", seen, err_timeout_o, err_len_o);
      end
      m_busy = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready_o !== 1'b1 || done_o !== 1'b0) begin
         errors++; $display("FAIL timeout_ready: rdy=%b done=%b want rdy=1 done=0", req_ready_o, done_o);
      end
   endtask

   task automatic test_reset_mid();
      do_req(7'h37, 1'b1, 8'd2);
      cmd_handshake();
      m_busy = 1'b1; m_missed_ack = 1'b1;
      mrd_tdata = 8'h99; mrd_tvalid = 1'b1; rd_tready = 1'b0;
      @(posedge clk); @(negedge clk);
      m_missed_ack = 1'b0;
      checks++;
      if (rd_tvalid_o !== 1'b1 || mrd_tready_o !== 1'b0 || err_nack_o !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre: rdv=%b mrdy=%b nack=%b want rdv=1 mrdy=0 nack=1", rd_tvalid_o, mrd_tready_o, err_nack_o);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (rd_tvalid_o !== 1'b0 || cmd_valid_o !== 1'b0 || mrd_tready_o !== 1'b0 || err_nack_o !== 1'b0 ||
          req_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_async: rdv=%b cv=%b mrdy=%b nack=%b rdy=%b want all 0",
                  rd_tvalid_o, cmd_valid_o, mrd_tready_o, err_nack_o, req_ready_o);
      end
      @(negedge clk);
      rst = 1'b0; mrd_tvalid = 1'b0; m_busy = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready_o !== 1'b1 || err_nack_o !== 1'b0 || err_len_o !== 1'b0 || err_timeout_o !== 1'b0 ||
          bytes_done_o !== 8'd0) begin
         errors++;
         $display("FAIL rstmid_after: rdy=%b errs=%b%b%b bytes=%0d want rdy=1 errs=000 bytes=0",
                  req_ready_o, err_nack_o, err_len_o, err_timeout_o, bytes_done_o);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_len_zero();
      test_nack();
      test_early_tlast();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
